// File: rtl/ewrapper_txo_pkg.sv
// Shared types and constants for the eLink TX framer: FSM states, frame masks,
// transaction layout and the 13-byte packet builder.
package ewrapper_txo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEAD,
        ST_TAIL
    } state_t;

    localparam logic [7:0] FRAME_HEAD     = 8'hFF;
    localparam logic [7:0] FRAME_TAIL     = 8'hF8;
    localparam logic [7:0] FRAME_TAIL_PAR = 8'hFC;

    localparam int PKT_BYTES = 13;
    localparam int SLOTS     = 8;
    localparam int LANES     = 9;

    typedef struct packed {
        logic        write;
        logic [1:0]  datamode;
        logic [3:0]  ctrlmode;
        logic [31:0] dstaddr;
        logic [31:0] data;
        logic [31:0] srcaddr;
    } txn_t;

    // Element i is packet byte Bi.
    typedef logic [PKT_BYTES-1:0][7:0] pkt_t;

    function automatic pkt_t frame_bytes(input txn_t t);
        pkt_t p;
        p[0] = {t.ctrlmode, t.datamode, t.write, 1'b1};
        for (int i = 0; i < 4; i++) begin
            p[1+i] = t.dstaddr[31-8*i -: 8];
            p[5+i] = t.data[31-8*i -: 8];
            p[9+i] = t.srcaddr[31-8*i -: 8];
        end
        return p;
    endfunction

    function automatic logic [7:0] pkt_parity(input pkt_t p);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < PKT_BYTES; i++) x ^= p[i];
        return x;
    endfunction

endpackage

// File: rtl/ewrapper_txo_slot_pack.sv
// Packs 8 byte-slots plus a frame mask into the serializer's 72-bit lane order:
// slot t, bit k lands on word[8k+7-t]; frame mask occupies word[71:64].
module ewrapper_txo_slot_pack
    import ewrapper_txo_pkg::*;
(
    input  logic [SLOTS-1:0][7:0]     slot_bytes,
    input  logic [7:0]                frame,
    output logic [SLOTS*LANES-1:0]    word
);

    for (genvar t = 0; t < SLOTS; t++) begin : g_slot
        for (genvar k = 0; k < 8; k++) begin : g_lane
            assign word[8*k+7-t] = slot_bytes[t][k];
        end
    end

    // Mask bit 7 is slot 0, so the mask byte maps straight onto the frame lane.
    assign word[8*SLOTS +: 8] = frame;

endmodule

// File: rtl/ewrapper_txo_framer.sv
// Frames one emesh transaction into a HEAD/TAIL pair of 72-bit slot words.
// Build option TXO_FRAMER_PARITY_EN adds an XOR parity byte in TAIL slot 5.
module ewrapper_txo_framer
    import ewrapper_txo_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE = 8'h00
)(
    input  logic                       CLK_DIV_IN,
    input  logic                       RESET_N,
    input  logic                       EMESH_ACCESS,
    input  logic                       EMESH_WRITE,
    input  logic [1:0]                 EMESH_DATAMODE,
    input  logic [3:0]                 EMESH_CTRLMODE,
    input  logic [31:0]                EMESH_DSTADDR,
    input  logic [31:0]                EMESH_DATA,
    input  logic [31:0]                EMESH_SRCADDR,
    output logic                       EMESH_WAIT,
    input  logic                       TX_WAIT_IN,
    output logic [SLOTS*LANES-1:0]     TX_DATA_OUT
);

    localparam int TAIL_BYTES = PKT_BYTES - SLOTS;

    txn_t   in_txn, buf_txn;
    logic   buf_valid;
    pkt_t   buf_pkt;
    logic   launch;
    state_t state, state_nxt;

    logic [TAIL_BYTES-1:0][7:0] shd_tail;
    logic [SLOTS-1:0][7:0]      head_b, tail_b, idle_b;
    logic [7:0]                 tail_frame;
    logic [SLOTS*LANES-1:0]     head_w, tail_w, idle_w, word_nxt;

    always_comb begin
        in_txn          = '0;
        in_txn.write    = EMESH_WRITE;
        in_txn.datamode = EMESH_DATAMODE;
        in_txn.ctrlmode = EMESH_CTRLMODE;
        in_txn.dstaddr  = EMESH_DSTADDR;
        in_txn.data     = EMESH_DATA;
        in_txn.srcaddr  = EMESH_SRCADDR;
    end

    assign buf_pkt    = frame_bytes(buf_txn);
    assign EMESH_WAIT = buf_valid;
    // A packet is only started from IDLE or TAIL, so TX_WAIT_IN never splits one.
    assign launch     = (state != ST_HEAD) && buf_valid && !TX_WAIT_IN;

    // Launch frees the buffer on the same edge, giving one accept every two cycles.
    always_ff @(posedge CLK_DIV_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            buf_valid <= 1'b0;
            buf_txn   <= '0;
            shd_tail  <= '0;
        end else if (launch) begin
            buf_valid <= 1'b0;
            shd_tail  <= buf_pkt[PKT_BYTES-1:SLOTS];
        end else if (EMESH_ACCESS && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_txn   <= in_txn;
        end
    end

`ifdef TXO_FRAMER_PARITY_EN
    logic [7:0] shd_par;

    always_ff @(posedge CLK_DIV_IN or negedge RESET_N) begin
        if (!RESET_N)    shd_par <= '0;
        else if (launch) shd_par <= pkt_parity(buf_pkt);
    end
`endif

    assign head_b = buf_pkt[SLOTS-1:0];
    assign idle_b = {SLOTS{IDLE_BYTE}};

    always_comb begin
        tail_b = {SLOTS{IDLE_BYTE}};
        for (int i = 0; i < TAIL_BYTES; i++) tail_b[i] = shd_tail[i];
`ifdef TXO_FRAMER_PARITY_EN
        tail_b[TAIL_BYTES] = shd_par;
        tail_frame         = FRAME_TAIL_PAR;
`else
        tail_frame         = FRAME_TAIL;
`endif
    end

    ewrapper_txo_slot_pack u_pack_head (.slot_bytes(head_b), .frame(FRAME_HEAD), .word(head_w));
    ewrapper_txo_slot_pack u_pack_tail (.slot_bytes(tail_b), .frame(tail_frame), .word(tail_w));
    ewrapper_txo_slot_pack u_pack_idle (.slot_bytes(idle_b), .frame(8'h00),      .word(idle_w));

    always_comb begin
        state_nxt = ST_IDLE;
        word_nxt  = idle_w;
        if (state == ST_HEAD) begin
            state_nxt = ST_TAIL;
            word_nxt  = tail_w;
        end else if (launch) begin
            state_nxt = ST_HEAD;
            word_nxt  = head_w;
        end
    end

    always_ff @(posedge CLK_DIV_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            TX_DATA_OUT <= '0;
        end else begin
            state       <= state_nxt;
            TX_DATA_OUT <= word_nxt;
        end
    end

endmodule

// File: tb/tb_ewrapper_txo_framer.sv
// Randomized/directed bench for ewrapper_txo_framer against a queue-based
// packet model built from the byte layout and lane mapping rules.
module tb_ewrapper_txo_framer;

    typedef struct {
        bit          wr;
        logic [1:0]  dm;
        logic [3:0]  cm;
        logic [31:0] dst;
        logic [31:0] dat;
        logic [31:0] src;
    } mtxn_t;
    typedef logic [7:0] pkt_arr_t  [13];
    typedef logic [7:0] slot_arr_t [8];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acc = 1'b0, wr = 1'b0, txw = 1'b0;
    logic [1:0]  dm = '0;
    logic [3:0]  cm = '0;
    logic [31:0] dst = '0, dat = '0, src = '0;
    logic        ewait;
    logic [71:0] txd;

    int n_vec = 0, n_err = 0;

    mtxn_t    pend[$];
    pkt_arr_t cur;
    bit       in_head = 0;
    int       acc_cnt = 0;
    logic [71:0] last_word;

    ewrapper_txo_framer dut (
        .CLK_DIV_IN(clk), .RESET_N(rst_n), .EMESH_ACCESS(acc), .EMESH_WRITE(wr),
        .EMESH_DATAMODE(dm), .EMESH_CTRLMODE(cm), .EMESH_DSTADDR(dst),
        .EMESH_DATA(dat), .EMESH_SRCADDR(src), .EMESH_WAIT(ewait),
        .TX_WAIT_IN(txw), .TX_DATA_OUT(txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic pkt_arr_t mkpkt(input mtxn_t t);
        pkt_arr_t p;
        p[0] = {t.cm, t.dm, t.wr, 1'b1};
        for (int i = 0; i < 4; i++) begin
            p[1+i] = t.dst >> (24 - 8*i);
            p[5+i] = t.dat >> (24 - 8*i);
            p[9+i] = t.src >> (24 - 8*i);
        end
        return p;
    endfunction

    function automatic logic [71:0] mkword(input slot_arr_t b, input logic [7:0] fr);
        logic [71:0] w;
        w = '0;
        for (int t = 0; t < 8; t++)
            for (int k = 0; k < 8; k++) w[8*k+7-t] = b[t][k];
        w[71:64] = fr;
        return w;
    endfunction

    function automatic logic [7:0] slot_byte(input logic [71:0] w, input int t);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = w[8*k+7-t];
        return b;
    endfunction

    function automatic logic [71:0] head_word(input pkt_arr_t p);
        slot_arr_t b;
        for (int t = 0; t < 8; t++) b[t] = p[t];
        return mkword(b, 8'hFF);
    endfunction

    function automatic logic [71:0] tail_word(input pkt_arr_t p);
        slot_arr_t b;
        logic [7:0] par;
        par = '0;
        for (int i = 0; i < 13; i++) par ^= p[i];
        for (int t = 0; t < 8; t++) b[t] = 8'h00;
        for (int t = 0; t < 5; t++) b[t] = p[8+t];
`ifdef TXO_FRAMER_PARITY_EN
        b[5] = par;
        return mkword(b, 8'hFC);
`else
        return mkword(b, 8'hF8);
`endif
    endfunction

    task automatic rand_txn();
        wr  = 1'($urandom);
        dm  = 2'($urandom);
        cm  = 4'($urandom);
        dst = $urandom;
        dat = $urandom;
        src = $urandom;
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs checked at negedge.
    task automatic cycle();
        logic [71:0] exp;
        bit          acc_now;
        mtxn_t       t;
        @(posedge clk);
        acc_now = acc && (pend.size() == 0);
        t = '{wr, dm, cm, dst, dat, src};
        if (in_head) begin
            exp = tail_word(cur);
            in_head = 0;
        end else if (pend.size() != 0 && !txw) begin
            cur = mkpkt(pend.pop_front());
            exp = head_word(cur);
            in_head = 1;
        end else begin
            exp = '0;
        end
        if (acc_now) begin
            pend.push_back(t);
            acc_cnt++;
        end
        @(negedge clk);
        chk("tx_data", txd, exp);
        chk("emesh_wait", {71'b0, ewait}, {71'b0, pend.size() != 0});
        last_word = txd;
    endtask

    initial begin
        int framed, first_i, last_i, start_cnt;

        // Reset held
        repeat (3) begin
            @(negedge clk);
            chk("reset_data", txd, 72'h0);
            chk("reset_wait", {71'b0, ewait}, 72'h0);
        end
        rst_n = 1'b1;
        repeat (3) cycle();

        // Single write, spec vector
        acc = 1; wr = 1; dm = 2'b10; cm = 4'h0;
        dst = 32'h8080_0000; dat = 32'hDEAD_BEEF; src = 32'h1234_5678;
        cycle();
        acc = 0;
        cycle();
        chk("head_lane0", {64'b0, txd[7:0]}, 72'h82);
        chk("head_frame", {64'b0, txd[71:64]}, 72'hFF);
        chk("head_slot0", {64'b0, slot_byte(txd, 0)}, 72'h0B);
        cycle();
        chk("tail_slot0", {64'b0, slot_byte(txd, 0)}, 72'hEF);
        chk("tail_slot4", {64'b0, slot_byte(txd, 4)}, 72'h78);
`ifdef TXO_FRAMER_PARITY_EN
        chk("tail_frame", {64'b0, txd[71:64]}, 72'hFC);
        chk("tail_parity", {64'b0, slot_byte(txd, 5)}, 72'h21);
`else
        chk("tail_frame", {64'b0, txd[71:64]}, 72'hF8);
        chk("tail_slot5", {64'b0, slot_byte(txd, 5)}, 72'h00);
`endif
        cycle();

        // Back-to-back: access held for 4 transactions
        framed = 0; first_i = -1; last_i = -1; start_cnt = acc_cnt;
        for (int i = 0; i < 16; i++) begin
            if (acc_cnt < start_cnt + 4) begin acc = 1; rand_txn(); end
            else acc = 0;
            cycle();
            if (last_word[71:64] != 8'h00) begin
                framed++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
        end
        acc = 0;
        chk("b2b_accepts", 72'(acc_cnt - start_cnt), 72'd4);
        chk("b2b_framed", 72'(framed), 72'd8);
        chk("b2b_span", 72'(last_i - first_i + 1), 72'd8);

        // Remote backpressure with a buffered transaction
        txw = 1; acc = 1; rand_txn();
        cycle();
        acc = 0;
        repeat (4) cycle();
        chk("bp_wait_held", {71'b0, ewait}, 72'h1);
        chk("bp_idle", txd, 72'h0);
        txw = 0;
        cycle();
        chk("bp_head_frame", {64'b0, txd[71:64]}, 72'hFF);
        txw = 1;
        cycle();
        chk("bp_tail_emitted", {71'b0, txd[71:64] != 8'h00}, 72'h1);
        txw = 0;
        cycle();

        // Reset during TAIL with a second transaction buffered
        acc = 1; rand_txn();
        cycle();
        cycle();
        acc = 1; rand_txn();
        cycle();
        acc = 0;
        #1 rst_n = 1'b0;
        #2;
        chk("async_reset_data", txd, 72'h0);
        chk("async_reset_wait", {71'b0, ewait}, 72'h0);
        #1 rst_n = 1'b1;
        pend.delete();
        in_head = 0;
        repeat (3) cycle();
        acc = 1; rand_txn();
        cycle();
        acc = 0;
        repeat (3) cycle();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            acc = ($urandom_range(0, 3) != 0);
            txw = ($urandom_range(0, 4) == 0);
            rand_txn();
            cycle();
        end
        acc = 0; txw = 0;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ewrapper_txo_framer.md
Name: ewrapper_txo_framer

Overview:
- Upstream feeder of the LVDS TX serializer, clocked by the core (divided) clock.
- Accepts one emesh transaction at a time through an access/wait handshake and frames it into a 13-byte eLink packet.
- Emits the packet as two 72-bit slot words, each word being 8 byte-slots by 9 lanes (lanes 0-7 carry data, lane 8 carries frame), ready for the serializer's DATA_OUT_FROM_DEVICE.
- Stalls at packet boundaries on remote backpressure.

Parameters:
- IDLE_BYTE, 8'h00, data value driven on lanes 0-7 in idle slots and pad slots.

Ports:
- CLK_DIV_IN  in  1  core clock, same clock as the serializer's slow clock.
- RESET_N  in  1  asynchronous, active-low reset.
- EMESH_ACCESS  in  1  transaction valid.
- EMESH_WRITE  in  1  write flag.
- EMESH_DATAMODE  in  2  access size.
- EMESH_CTRLMODE  in  4  control mode.
- EMESH_DSTADDR  in  32  destination address.
- EMESH_DATA  in  32  write data.
- EMESH_SRCADDR  in  32  source address.
- EMESH_WAIT  out  1  holding buffer full; the transaction is not accepted.
- TX_WAIT_IN  in  1  remote link backpressure, already synchronous to CLK_DIV_IN.
- TX_DATA_OUT  out  72  registered slot word to the serializer.

Behaviour:
- Clock and reset: one clock, CLK_DIV_IN. RESET_N is asynchronous, active-low.
- Reset values:
  - TX_DATA_OUT = {8'h00 frame, IDLE_BYTE on lanes}.
  - EMESH_WAIT = 0, buffer empty, FSM in IDLE.
- Accept:
  - Transaction is accepted at an edge where EMESH_ACCESS=1 and EMESH_WAIT=0; it is captured into a 1-entry holding buffer.
  - EMESH_WAIT = buf_valid (registered); there is no combinational path from the inputs.
- Packet bytes B0..B12:
  - B0 = {CTRLMODE[3:0], DATAMODE[1:0], WRITE, 1'b1}.
  - B1-B4 = DSTADDR, MSB first.
  - B5-B8 = DATA, MSB first.
  - B9-B12 = SRCADDR, MSB first.
- Lane mapping: slot t (t=0 is sent first), byte b:
  - TX_DATA_OUT[8k+7-t] = b[k] for k=0..7.
  - Frame bit is TX_DATA_OUT[71-t].
- FSM states and transitions:
  - IDLE: if buf_valid & ~TX_WAIT_IN, go to HEAD. Otherwise drive the idle word and stay.
  - HEAD: register slots B0-B7 with frame 8'hFF, copy the buffer into the tail shadow register, clear buf_valid. Then go to TAIL.
  - TAIL: register B8-B12 in slots 0-4, IDLE_BYTE in slots 5-7, frame 8'hF8.
  - From TAIL: go to HEAD if buf_valid & ~TX_WAIT_IN, else IDLE.
- Latency and throughput:
  - Accept at edge N → HEAD word visible after edge N+1 (when in IDLE or TAIL), TAIL word after N+2.
  - Sustained rate is 1 transaction per 2 cycles; back-to-back packets have no idle gap.
- TX_WAIT_IN:
  - Sampled only at the HEAD decision, so a packet is never split.
  - Asserting it during HEAD still lets TAIL complete.
- Simultaneous events: buffer cleared in HEAD and a new EMESH_ACCESS in the same cycle → no accept (EMESH_WAIT was 1). The next accept happens one cycle later.
- Reset mid-packet: packet is dropped, output returns to the idle word immediately (asynchronous), buffer is lost.

Optional Feature:
- Macro: TXO_FRAMER_PARITY_EN.
- Defined: TAIL slot 5 carries parity byte P = XOR of B0..B12, and the TAIL frame is 8'hFC.
- Undefined: slot 5 = IDLE_BYTE, frame is 8'hF8 as above.

Decomposition:
- Package ewrapper_txo_pkg holds:
  - state encoding (IDLE/HEAD/TAIL);
  - FRAME_HEAD=8'hFF, FRAME_TAIL=8'hF8, FRAME_TAIL_PAR=8'hFC;
  - PKT_BYTES=13, SLOTS=8, LANES=9.
- One combinational sub-module, ewrapper_txo_slot_pack: inputs are 8 bytes plus an 8-bit frame mask; output is the 72-bit word in lane order. Used for HEAD, TAIL and idle words.

Test Plan:
- Reset held, then released, with no access → TX_DATA_OUT = 72'h0 and EMESH_WAIT=0 for every cycle.
- Single write: WRITE=1, DATAMODE=2'b10, CTRLMODE=0, DSTADDR=32'h8080_0000, DATA=32'hDEAD_BEEF, SRCADDR=32'h1234_5678 → HEAD bytes 0B 80 80 00 00 DE AD BE with frame FF, so TX_DATA_OUT[7:0]=8'h82 and [71:64]=8'hFF. Next word is TAIL bytes EF 12 34 56 78 00 00 00 with frame F8.
- EMESH_ACCESS held high for 4 transactions → exactly 8 consecutive framed words, no idle word between packets. EMESH_WAIT pattern is 0,1,0,1,…
- TX_WAIT_IN=1 with a transaction buffered → idle words continue and EMESH_WAIT stays 1. Deassert TX_WAIT_IN → HEAD appears on the next edge. TX_WAIT_IN asserted during HEAD → TAIL is still emitted.
- RESET_N pulsed low during TAIL → output is zero asynchronously. After release: IDLE, buffer empty, and the next transaction is framed correctly.
- With TXO_FRAMER_PARITY_EN and the single-write stimulus above → TAIL slot 5 = 8'h21 and frame = 8'hFC.
